// File: rtl/decode_regfile_pkg.sv
// Shared decode definitions: opcodes, branch funct3 codes
// and the immediate-format classifier.
package decode_regfile_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_SHAMT,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_kind_t;

    function automatic imm_kind_t imm_kind(
        input logic [6:0] op,
        input logic [2:0] f3
    );
        logic shift;
        shift = (op == OP_IMM) &&
                ((f3 == F3_SLL) || (f3 == F3_SRX));
        imm_kind = IMM_NONE;
        unique case (1'b1)
            shift:
                imm_kind = IMM_SHAMT;
            (op == OP_IMM && !shift),
            (op == OP_LOAD),
            (op == OP_JALR),
            (op == OP_SYSTEM):
                imm_kind = IMM_I;
            (op == OP_STORE):
                imm_kind = IMM_S;
            (op == OP_BRANCH):
                imm_kind = IMM_B;
            (op == OP_LUI),
            (op == OP_AUIPC):
                imm_kind = IMM_U;
            (op == OP_JAL):
                imm_kind = IMM_J;
            default:
                imm_kind = IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/decode_regfile_imm_gen.sv
// Immediate generator: pure combinational inst -> imm32.
// Unknown and R-type opcodes yield zero.
module decode_regfile_imm_gen
    import decode_regfile_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm32
);

    imm_kind_t kind;

    always_comb begin
        kind  = imm_kind(inst[6:0], inst[14:12]);
        imm32 = '0;
        unique case (kind)
            IMM_I:
                imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_SHAMT:
                imm32 = {27'b0, inst[24:20]};
            IMM_S:
                imm32 = {{20{inst[31]}}, inst[31:25],
                         inst[11:7]};
            IMM_B:
                imm32 = {{19{inst[31]}}, inst[31], inst[7],
                         inst[30:25], inst[11:8], 1'b0};
            IMM_U:
                imm32 = {inst[31:12], 12'b0};
            IMM_J:
                imm32 = {{11{inst[31]}}, inst[31],
                         inst[19:12], inst[20],
                         inst[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

endmodule

// File: rtl/decode_regfile.sv
// Decode stage: 32x32 register file with write-back bypass,
// immediate generation and branch-compare flags for fetch.
module decode_regfile
    import decode_regfile_pkg::*;
#(
    parameter logic [31:0] SP_INIT = 32'h0000_7FFC,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] imm32,
    output logic [4:0]  rd_addr,
    output logic [2:0]  branch_type,
    output logic        zero,
    output logic        less,
    output logic [31:0] dbg_data
);

    logic [31:0] regs [1:31];
    logic        wr_live;

    assign wr_live = wb_en && (wb_addr != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= (i == 2) ? SP_INIT : 32'd0;
            end
        end else if (wr_live) begin
            regs[wb_addr] <= wb_data;
        end
    end

    function automatic logic [31:0] rd_port(
        input logic [4:0] a
    );
        if (a == 5'd0) begin
            return 32'd0;
        end else if (BYPASS && wr_live && wb_addr == a) begin
            return wb_data;
        end else begin
            return regs[a];
        end
    endfunction

    always_comb begin
        rs1_data = rd_port(inst[19:15]);
        rs2_data = rd_port(inst[24:20]);
        dbg_data = rd_port(dbg_addr);
    end

    // inst[13] splits blt/bge (signed) from bltu/bgeu
    always_comb begin
        zero = (rs1_data == rs2_data);
        if (inst[13]) begin
            less = rs1_data < rs2_data;
        end else begin
            less = $signed(rs1_data) < $signed(rs2_data);
        end
    end

    assign rd_addr     = inst[11:7];
    assign branch_type = inst[14:12];

    decode_regfile_imm_gen u_imm (
        .inst  (inst),
        .imm32 (imm32)
    );

endmodule

// File: tb/tb_decode_regfile.sv
// Directed self-checking bench for decode_regfile, with a
// second BYPASS=0 instance for same-cycle write/read checks.
module tb_decode_regfile;

    logic        clk;
    logic        rst;
    logic [31:0] inst;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  dbg_addr;

    logic [31:0] rs1_data, rs2_data, imm32, dbg_data;
    logic [4:0]  rd_addr;
    logic [2:0]  branch_type;
    logic        zero, less;

    logic [31:0] rs1_b, rs2_b, imm_b, dbg_b;
    logic [4:0]  rd_b;
    logic [2:0]  bt_b;
    logic        zero_b, less_b;

    localparam logic [31:0] SP = 32'h0000_7FFC;

    int nvec = 0;
    int nerr = 0;

    decode_regfile #(.SP_INIT(SP), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .inst(inst),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .dbg_addr(dbg_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm32(imm32), .rd_addr(rd_addr),
        .branch_type(branch_type),
        .zero(zero), .less(less), .dbg_data(dbg_data)
    );

    decode_regfile #(.SP_INIT(SP), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .inst(inst),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .dbg_addr(dbg_addr),
        .rs1_data(rs1_b), .rs2_data(rs2_b),
        .imm32(imm_b), .rd_addr(rd_b),
        .branch_type(bt_b),
        .zero(zero_b), .less(less_b), .dbg_data(dbg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm;
        logic [2:0]  bt;
        logic [4:0]  rd;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
        @(posedge clk);
        #1;
        wb_en   = 1'b0;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] r1,
                                          input logic [4:0] r2,
                                          input logic [2:0] f3);
        rtype = {7'd0, r2, r1, f3, 5'd0, 7'b1100011};
    endfunction

    initial begin
        tbl.push_back('{32'hFE20_8CE3, 32'hFFFF_FFF8, 3'b000, 5'd25});
        tbl.push_back('{32'h0000_A0B7, 32'h0000_A000, 3'b010, 5'd1});
        tbl.push_back('{32'h8000_00B7, 32'h8000_0000, 3'b000, 5'd1});
        tbl.push_back('{32'h1234_5017, 32'h1234_5000, 3'b101, 5'd0});
        tbl.push_back('{32'hFFF0_0093, 32'hFFFF_FFFF, 3'b000, 5'd1});
        tbl.push_back('{32'h01F0_9093, 32'h0000_001F, 3'b001, 5'd1});
        tbl.push_back('{32'h4030_D093, 32'h0000_0003, 3'b101, 5'd1});
        tbl.push_back('{32'h0081_2083, 32'h0000_0008, 3'b010, 5'd1});
        tbl.push_back('{32'hFF02_80E7, 32'hFFFF_FFF0, 3'b000, 5'd1});
        tbl.push_back('{32'h3052_9073, 32'h0000_0305, 3'b001, 5'd0});
        tbl.push_back('{32'hFE20_AE23, 32'hFFFF_FFFC, 3'b010, 5'd28});
        tbl.push_back('{32'h0010_00EF, 32'h0000_0800, 3'b000, 5'd1});
        tbl.push_back('{32'hFFDF_F06F, 32'hFFFF_FFFC, 3'b111, 5'd0});
        tbl.push_back('{32'h0020_81B3, 32'h0000_0000, 3'b000, 5'd3});
        tbl.push_back('{32'hFFF0_000F, 32'h0000_0000, 3'b000, 5'd0});

        inst     = '0;
        wb_en    = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        dbg_addr = '0;
        rst      = 1'b1;
        #1 rst   = 1'b0;
        #2;
        chk("rst_rs1", rs1_data, 32'd0);
        chk("rst_rs2", rs2_data, 32'd0);
        chk("rst_imm", imm32, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        chk("rst_less", {31'd0, less}, 32'd0);
        #4 rst = 1'b1;

        for (int a = 0; a < 32; a++) begin
            dbg_addr = a[4:0];
            #1;
            chk($sformatf("rst_x%0d", a), dbg_data,
                (a == 2) ? SP : 32'd0);
        end
        inst = {12'd0, 5'd2, 3'd0, 5'd0, 7'b0010011};
        #1 chk("sp_rs1", rs1_data, SP);

        // x0 write: no bypass, no storage
        @(negedge clk);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
        dbg_addr = 5'd0;
        #1 chk("x0_byp", dbg_data, 32'd0);
        @(posedge clk); #1;
        wb_en = 1'b0;
        chk("x0_after", dbg_data, 32'd0);

        wr(5'd5, 32'h1234_5678);
        inst = {12'd0, 5'd5, 3'd0, 5'd0, 7'b0010011};
        #1 chk("x5_rs1", rs1_data, 32'h1234_5678);
        chk("x5_imm", imm32, 32'd0);

        // same-cycle write/read of x7
        @(negedge clk);
        inst = {7'd0, 5'd7, 5'd0, 3'd0, 5'd1, 7'b0110011};
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hA5A5_0000;
        dbg_addr = 5'd7;
        #1;
        chk("byp_rs2", rs2_data, 32'hA5A5_0000);
        chk("byp_dbg", dbg_data, 32'hA5A5_0000);
        chk("nb_rs2_old", rs2_b, 32'd0);
        chk("nb_dbg_old", dbg_b, 32'd0);
        @(posedge clk); #1;
        wb_en = 1'b0;
        chk("nb_rs2_new", rs2_b, 32'hA5A5_0000);
        chk("byp_rs2_kept", rs2_data, 32'hA5A5_0000);

        foreach (tbl[i]) begin
            inst = tbl[i].inst;
            #1;
            chk($sformatf("imm[%0d]", i), imm32, tbl[i].imm);
            chk($sformatf("bt[%0d]", i),
                {29'd0, branch_type}, {29'd0, tbl[i].bt});
            chk($sformatf("rd[%0d]", i),
                {27'd0, rd_addr}, {27'd0, tbl[i].rd});
        end

        wr(5'd1, 32'hFFFF_FFFF);
        wr(5'd2, 32'd1);
        inst = rtype(5'd1, 5'd2, 3'b100);
        #1;
        chk("blt_less", {31'd0, less}, 32'd1);
        chk("blt_zero", {31'd0, zero}, 32'd0);
        inst = rtype(5'd1, 5'd2, 3'b101);
        #1 chk("bge_less", {31'd0, less}, 32'd1);
        inst = rtype(5'd1, 5'd2, 3'b110);
        #1;
        chk("bltu_less", {31'd0, less}, 32'd0);
        chk("bltu_zero", {31'd0, zero}, 32'd0);
        inst = rtype(5'd2, 5'd1, 3'b111);
        #1 chk("bgeu_less_rev", {31'd0, less}, 32'd1);

        wr(5'd2, 32'd3);
        @(negedge clk);
        inst = rtype(5'd1, 5'd2, 3'b000);
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd3;
        #1;
        chk("byp_zero", {31'd0, zero}, 32'd1);
        chk("byp_less", {31'd0, less}, 32'd0);
        chk("nb_zero_old", {31'd0, zero_b}, 32'd0);
        @(posedge clk); #1;
        wb_en = 1'b0;
        chk("eq_zero", {31'd0, zero}, 32'd1);
        chk("eq_less", {31'd0, less}, 32'd0);

        // asynchronous reset between edges
        wr(5'd9, 32'd5);
        dbg_addr = 5'd9;
        #1 chk("x9_set", dbg_data, 32'd5);
        #2 rst = 1'b0;
        #1 chk("x9_async", dbg_data, 32'd0);
        dbg_addr = 5'd2;
        #1 chk("x2_async", dbg_data, SP);
        @(negedge clk);
        wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'd77;
        @(posedge clk); #1;
        wb_en = 1'b0;
        dbg_addr = 5'd10;
        #1 chk("x10_in_rst", dbg_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("x10_after", dbg_data, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
